// File: rtl/fp_pkg.sv
// Shared FP64 definitions for the FP unit compare path.
// Holds field positions of the IEEE-754 double format, the all-ones exponent
// pattern and the compare opcode encoding used by fp_compare_pipe.
package fp_pkg;

    localparam int unsigned FP_SIGN     = 63;
    localparam int unsigned FP_EXP_MSB  = 62;
    localparam int unsigned FP_EXP_LSB  = 52;
    localparam int unsigned FP_MAN_MSB  = 51;
    localparam int unsigned FP_MAN_LSB  = 0;
    // Mantissa MSB distinguishes quiet (1) from signalling (0) NaNs.
    localparam int unsigned FP_QNAN_BIT = 51;

    localparam logic [10:0] EXP_ALL_ONES = 11'h7FF;

    typedef enum logic [1:0] {
        FP_CMP_FLE = 2'b00,
        FP_CMP_FLT = 2'b01,
        FP_CMP_FEQ = 2'b10,
        FP_CMP_RSV = 2'b11
    } fp_cmp_op_e;

endpackage

// File: rtl/fp_classify.sv
// Combinational FP64 operand classifier.
// Ports:
//   in_num       - FP64 operand
//   out_is_neg   - sign bit
//   out_is_nan   - exponent all ones and mantissa non-zero
//   out_is_snan  - NaN with the quiet bit clear
//   out_is_zero  - +0 or -0 (bits 62:0 all zero)
module fp_classify
    import fp_pkg::*;
(
    input  logic [63:0] in_num,
    output logic        out_is_neg,
    output logic        out_is_nan,
    output logic        out_is_snan,
    output logic        out_is_zero
);

    logic [10:0] exp_f;
    logic [51:0] man_f;

    always_comb begin
        exp_f       = in_num[FP_EXP_MSB:FP_EXP_LSB];
        man_f       = in_num[FP_MAN_MSB:FP_MAN_LSB];
        out_is_neg  = in_num[FP_SIGN];
        out_is_nan  = (exp_f == EXP_ALL_ONES) && (man_f != '0);
        out_is_snan = out_is_nan && !in_num[FP_QNAN_BIT];
        out_is_zero = (exp_f == '0) && (man_f == '0);
    end

endmodule

// File: rtl/fp_compare_pipe.sv
// Two-stage pipelined FP64 compare (FLE / FLT / FEQ) with valid/ready on
// both sides. Stage 1 classifies operands and does the magnitude compares;
// stage 2 resolves sign handling, NaN rules and the opcode.
// Ports:
//   in_clk, in_rst (async, active high), in_flush (sync, kills in-flight ops)
//   in_valid / out_ready      - upstream handshake
//   in_numA, in_numB          - FP64 operands
//   in_ctrl_op                - 00 FLE, 01 FLT, 10 FEQ, 11 reserved
//   in_tag                    - opaque tag returned with the result
//   out_valid / in_ready      - downstream handshake
//   out_data                  - zero-extended boolean result
//   out_flag_nv               - invalid-operation flag
//   out_flag_illegal          - reserved opcode was issued
//   out_tag                   - tag of the result
module fp_compare_pipe
    import fp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned TAG_WIDTH  = 5
) (
    input  logic                  in_clk,
    input  logic                  in_rst,
    input  logic                  in_flush,
    input  logic                  in_valid,
    output logic                  out_ready,
    input  logic [DATA_WIDTH-1:0] in_numA,
    input  logic [DATA_WIDTH-1:0] in_numB,
    input  logic [1:0]            in_ctrl_op,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_flag_nv,
    output logic                  out_flag_illegal,
    output logic [TAG_WIDTH-1:0]  out_tag
);

    typedef struct packed {
        logic                 nan_a;
        logic                 snan_a;
        logic                 nan_b;
        logic                 snan_b;
        logic                 both_zero;
        logic                 sign_a;
        logic                 sign_b;
        logic                 mag_lt;
        logic                 mag_eq;
        fp_cmp_op_e           op;
        logic [TAG_WIDTH-1:0] tag;
    } s1_t;

    logic neg_a, nan_a, snan_a, zero_a;
    logic neg_b, nan_b, snan_b, zero_b;

    fp_classify u_cls_a (
        .in_num      (in_numA),
        .out_is_neg  (neg_a),
        .out_is_nan  (nan_a),
        .out_is_snan (snan_a),
        .out_is_zero (zero_a)
    );

    fp_classify u_cls_b (
        .in_num      (in_numB),
        .out_is_neg  (neg_b),
        .out_is_nan  (nan_b),
        .out_is_snan (snan_b),
        .out_is_zero (zero_b)
    );

    logic                 s1_valid_q, s1_valid_d;
    s1_t                  s1_q, s1_d;
    logic                 s2_valid_q, s2_valid_d;
    logic                 res_q, res_d;
    logic                 nv_q, nv_d;
    logic                 ill_q, ill_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;

    logic adv1, adv2;
    logic any_nan, eq, lt;

    always_comb begin
        adv2 = !s2_valid_q || in_ready;
        adv1 = !s1_valid_q || adv2;

        // Stage 1
        s1_d = s1_q;
        if (adv1) begin
            s1_d.nan_a     = nan_a;
            s1_d.snan_a    = snan_a;
            s1_d.nan_b     = nan_b;
            s1_d.snan_b    = snan_b;
            s1_d.both_zero = zero_a && zero_b;
            s1_d.sign_a    = neg_a;
            s1_d.sign_b    = neg_b;
            s1_d.mag_lt    = in_numA[DATA_WIDTH-2:0] <  in_numB[DATA_WIDTH-2:0];
            s1_d.mag_eq    = in_numA[DATA_WIDTH-2:0] == in_numB[DATA_WIDTH-2:0];
            s1_d.op        = fp_cmp_op_e'(in_ctrl_op);
            s1_d.tag       = in_tag;
        end

        if (in_flush)  s1_valid_d = 1'b0;
        else if (adv1) s1_valid_d = in_valid;
        else           s1_valid_d = s1_valid_q;

        // Stage 2 compare resolution
        any_nan = s1_q.nan_a || s1_q.nan_b;
        eq = s1_q.both_zero || ((s1_q.sign_a == s1_q.sign_b) && s1_q.mag_eq);
        if (s1_q.sign_a != s1_q.sign_b) lt = s1_q.sign_a && !s1_q.both_zero;
        else if (!s1_q.sign_a)          lt = s1_q.mag_lt;
        else                            lt = !s1_q.mag_lt && !s1_q.mag_eq;
        if (any_nan) begin
            eq = 1'b0;
            lt = 1'b0;
        end

        res_d = res_q;
        nv_d  = nv_q;
        ill_d = ill_q;
        tag_d = tag_q;
        if (adv2) begin
            tag_d = s1_q.tag;
            ill_d = 1'b0;
            case (s1_q.op)
                FP_CMP_FLE: begin res_d = lt || eq; nv_d = any_nan; end
                FP_CMP_FLT: begin res_d = lt;       nv_d = any_nan; end
                FP_CMP_FEQ: begin res_d = eq;       nv_d = s1_q.snan_a || s1_q.snan_b; end
                default:    begin res_d = 1'b0;     nv_d = 1'b0; ill_d = 1'b1; end
            endcase
        end

        if (in_flush)  s2_valid_d = 1'b0;
        else if (adv2) s2_valid_d = s1_valid_q;
        else           s2_valid_d = s2_valid_q;
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            res_q      <= 1'b0;
            nv_q       <= 1'b0;
            ill_q      <= 1'b0;
            tag_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            res_q      <= res_d;
            nv_q       <= nv_d;
            ill_q      <= ill_d;
            tag_q      <= tag_d;
        end
    end

    assign out_ready        = adv1;
    assign out_valid        = s2_valid_q;
    assign out_data         = {{(DATA_WIDTH-1){1'b0}}, res_q};
    assign out_flag_nv      = nv_q;
    assign out_flag_illegal = ill_q;
    assign out_tag          = tag_q;

endmodule

// File: tb/tb_fp_compare_pipe.sv
// Scoreboard bench for fp_compare_pipe: directed compare vectors with
// hand-computed results, backpressure, flush and asynchronous reset.
module tb_fp_compare_pipe;
    import fp_pkg::*;

    localparam logic [63:0] ONE  = 64'h3FF0000000000000;
    localparam logic [63:0] TWO  = 64'h4000000000000000;
    localparam logic [63:0] M1   = 64'hBFF0000000000000;
    localparam logic [63:0] M2   = 64'hC000000000000000;
    localparam logic [63:0] PZ   = 64'h0000000000000000;
    localparam logic [63:0] NZ   = 64'h8000000000000000;
    localparam logic [63:0] QNAN = 64'h7FF8000000000000;
    localparam logic [63:0] SNAN = 64'h7FF0000000000001;
    localparam logic [1:0]  OP_FLE = FP_CMP_FLE;
    localparam logic [1:0]  OP_FLT = FP_CMP_FLT;
    localparam logic [1:0]  OP_FEQ = FP_CMP_FEQ;
    localparam logic [1:0]  OP_RSV = 2'b11;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic [63:0] a, b;
    logic [1:0]  op;
    logic [4:0]  tag;
    logic        out_ready, out_valid, out_nv, out_ill;
    logic [63:0] out_data;
    logic [4:0]  out_tag;

    fp_compare_pipe #(.DATA_WIDTH(64), .TAG_WIDTH(5)) dut (
        .in_clk           (clk),
        .in_rst           (rst),
        .in_flush         (flush),
        .in_valid         (in_valid),
        .out_ready        (out_ready),
        .in_numA          (a),
        .in_numB          (b),
        .in_ctrl_op       (op),
        .in_tag           (tag),
        .out_valid        (out_valid),
        .in_ready         (in_ready),
        .out_data         (out_data),
        .out_flag_nv      (out_nv),
        .out_flag_illegal (out_ill),
        .out_tag          (out_tag)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;
    bit hold_en  = 1'b1;

    typedef struct {
        logic       res;
        logic       nv;
        logic       ill;
        logic [4:0] tag;
        longint     acc;
        bit         exact;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Presents one operation and waits (bounded) for it to be accepted.
    // push=0 marks an operation that is expected to be killed later.
    task automatic send(input logic [1:0] o, input logic [63:0] xa, input logic [63:0] xb,
                        input logic [4:0] t, input logic r, input logic nv, input logic ill,
                        input bit push, input bit exact);
        exp_t e;
        bit   done;
        done = 1'b0;
        in_valid = 1'b1; op = o; a = xa; b = xb; tag = t;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (out_ready) begin
                if (push) begin
                    e.res = r; e.nv = nv; e.ill = ill; e.tag = t;
                    e.acc = cyc; e.exact = exact;
                    sb.push_back(e);
                end
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_checks++; n_err++;
            $display("FAIL accept_timeout: tag %0d never accepted", t);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: stability while stalled, and scoreboard pop on each transfer.
    logic        pv;
    logic [63:0] pdata;
    logic        pnv, pill;
    logic [4:0]  ptag;
    initial begin
        exp_t e;
        pv = 1'b0;
        forever begin
            @(negedge clk);
            if (hold_en && pv) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data",  out_data, pdata);
                chk("hold_nv",    64'(out_nv), 64'(pnv));
                chk("hold_ill",   64'(out_ill), 64'(pill));
                chk("hold_tag",   64'(out_tag), 64'(ptag));
            end
            if (out_valid && in_ready && !rst) begin
                if (sb.size() == 0) begin
                    chk("spurious_valid", 64'(out_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("data",    out_data, 64'(e.res));
                    chk("nv",      64'(out_nv), 64'(e.nv));
                    chk("illegal", 64'(out_ill), 64'(e.ill));
                    chk("tag",     64'(out_tag), 64'(e.tag));
                    if (e.exact) chk("latency", 64'(cyc - e.acc), 64'd2);
                end
            end
            pv = out_valid && !in_ready; pdata = out_data;
            pnv = out_nv; pill = out_ill; ptag = out_tag;
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ready = 1'b1;
        a = '0; b = '0; op = '0; tag = '0;
        #12;
        chk("rst_out_ready", 64'(out_ready), 64'd1);
        @(posedge clk); #1 rst = 1'b0;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data",  out_data, 64'd0);
        chk("rst_nv",    64'(out_nv), 64'd0);
        chk("rst_ill",   64'(out_ill), 64'd0);
        chk("rst_tag",   64'(out_tag), 64'd0);
        chk("rst_ready", 64'(out_ready), 64'd1);

        // Directed vectors, back-to-back, no backpressure
        send(OP_FLT, ONE,  TWO,  5'd1,  1'b1, 1'b0, 1'b0, 1, 1);
        send(OP_FLT, TWO,  ONE,  5'd2,  1'b0, 1'b0, 1'b0, 1, 1);
        send(OP_FEQ, NZ,   PZ,   5'd3,  1'b1, 1'b0, 1'b0, 1, 1);
        send(OP_FLT, NZ,   PZ,   5'd4,  1'b0, 1'b0, 1'b0, 1, 1);
        send(OP_FLE, NZ,   PZ,   5'd5,  1'b1, 1'b0, 1'b0, 1, 1);
        send(OP_FEQ, QNAN, ONE,  5'd6,  1'b0, 1'b0, 1'b0, 1, 1);
        send(OP_FLE, QNAN, ONE,  5'd7,  1'b0, 1'b1, 1'b0, 1, 1);
        send(OP_FEQ, SNAN, ONE,  5'd8,  1'b0, 1'b1, 1'b0, 1, 1);
        send(OP_FLT, M2,   M1,   5'd9,  1'b1, 1'b0, 1'b0, 1, 1);
        send(OP_FLE, M1,   M2,   5'd10, 1'b0, 1'b0, 1'b0, 1, 1);
        send(OP_FEQ, ONE,  ONE,  5'd11, 1'b1, 1'b0, 1'b0, 1, 1);
        send(OP_FLT, ONE,  ONE,  5'd12, 1'b0, 1'b0, 1'b0, 1, 1);
        send(OP_FLE, ONE,  ONE,  5'd13, 1'b1, 1'b0, 1'b0, 1, 1);
        send(OP_FLT, M1,   ONE,  5'd14, 1'b1, 1'b0, 1'b0, 1, 1);
        send(OP_FLT, PZ,   NZ,   5'd15, 1'b0, 1'b0, 1'b0, 1, 1);
        send(OP_FLE, PZ,   NZ,   5'd16, 1'b1, 1'b0, 1'b0, 1, 1);
        send(OP_FLT, TWO,  QNAN, 5'd17, 1'b0, 1'b1, 1'b0, 1, 1);
        send(OP_RSV, QNAN, SNAN, 5'd18, 1'b0, 1'b0, 1'b1, 1, 1);
        send(OP_RSV, ONE,  TWO,  5'd19, 1'b0, 1'b0, 1'b1, 1, 1);
        in_valid = 1'b0;
        drain();

        // Backpressure: in_ready low for 3 cycles while 4 ops stream in
        in_ready = 1'b0;
        fork
            begin
                send(OP_FLE, TWO,  ONE, 5'd20, 1'b0, 1'b0, 1'b0, 1, 0);
                send(OP_FLT, M1,   TWO, 5'd21, 1'b1, 1'b0, 1'b0, 1, 0);
                send(OP_FEQ, TWO,  TWO, 5'd22, 1'b1, 1'b0, 1'b0, 1, 0);
                send(OP_FLT, SNAN, ONE, 5'd23, 1'b0, 1'b1, 1'b0, 1, 0);
                in_valid = 1'b0;
            end
            begin
                @(posedge clk);
                @(posedge clk);
                @(negedge clk);
                chk("bp_ready_low", 64'(out_ready), 64'd0);
                @(posedge clk);
                #1 in_ready = 1'b1;
            end
        join
        drain();

        // Flush with two ops in flight plus one presented in the flush cycle
        hold_en = 1'b0;
        in_ready = 1'b0;
        send(OP_FEQ, ONE, ONE, 5'd24, 1'b1, 1'b0, 1'b0, 0, 0);
        send(OP_FEQ, TWO, TWO, 5'd25, 1'b1, 1'b0, 1'b0, 0, 0);
        flush = 1'b1; in_valid = 1'b1; op = OP_FLT; a = ONE; b = TWO; tag = 5'd26;
        @(negedge clk);
        chk("flush_pre_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; in_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("flush_no_valid", 64'(out_valid), 64'd0);
        end

        // Asynchronous reset mid-stream
        @(posedge clk); #1;
        in_ready = 1'b0;
        send(OP_FLE, ONE, TWO, 5'd27, 1'b1, 1'b0, 1'b0, 0, 0);
        send(OP_FLT, ONE, TWO, 5'd28, 1'b1, 1'b0, 1'b0, 0, 0);
        in_valid = 1'b0;
        chk("prerst_valid", 64'(out_valid), 64'd1);
        chk("prerst_tag",   64'(out_tag), 64'd27);
        #3 rst = 1'b1;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_data",  out_data, 64'd0);
        chk("arst_nv",    64'(out_nv), 64'd0);
        chk("arst_ill",   64'(out_ill), 64'd0);
        chk("arst_tag",   64'(out_tag), 64'd0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        chk("arst_ready", 64'(out_ready), 64'd1);
        in_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("arst_no_valid", 64'(out_valid), 64'd0);
        end
        @(posedge clk); #1;
        hold_en = 1'b1;

        // Pipe still works after reset
        send(OP_FLT, ONE, TWO, 5'd29, 1'b1, 1'b0, 1'b0, 1, 1);
        in_valid = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/fp_compare_pipe.md
Name: fp_compare_pipe

Overview:
- Pipelined IEEE-754 double-precision compare unit implementing FEQ, FLT and FLE for the FP unit.
- Answers the compare question directly: it returns a boolean result plus an invalid-operation flag, not a selected operand.
- Two-stage pipeline with a valid/ready handshake on both sides, so it can sit behind the issue stage and stall on writeback backpressure.
- Results are zero-extended to DATA_WIDTH for the integer register write port.

Parameters:
- DATA_WIDTH, 64, operand and result width; only 64 is supported (sign bit 63, exponent 62:52, mantissa 51:0).
- TAG_WIDTH, 5, width of the opaque tag (destination register) carried alongside each operation.

Ports:
- in_clk  input  1  clock; all state updates on its rising edge.
- in_rst  input  1  asynchronous, active-high reset.
- in_flush  input  1  synchronous flush; kills all in-flight operations.
- in_valid  input  1  upstream presents an operation.
- out_ready  output  1  unit accepts an operation this cycle.
- in_numA  input  DATA_WIDTH  operand A.
- in_numB  input  DATA_WIDTH  operand B.
- in_ctrl_op  input  2  00 = FLE, 01 = FLT, 10 = FEQ, 11 = reserved.
- in_tag  input  TAG_WIDTH  tag returned with the result.
- out_valid  output  1  result is valid.
- in_ready  input  1  downstream accepts the result.
- out_data  output  DATA_WIDTH  {63'b0, result}.
- out_flag_nv  output  1  invalid-operation exception flag.
- out_flag_illegal  output  1  reserved opcode was issued.
- out_tag  output  TAG_WIDTH  tag of the result.

Behaviour:
- Reset: s1_valid, s2_valid, out_valid, out_data, out_flag_nv, out_flag_illegal and out_tag are all 0. out_ready = 1 after reset.
- Handshake:
  - Input transfer occurs when in_valid & out_ready.
  - Output transfer occurs when out_valid & in_ready.
  - out_valid and all outputs stay stable while out_valid & !in_ready.
- Pipeline control:
  - adv2 = !s2_valid | in_ready.
  - adv1 = !s1_valid | adv2.
  - out_ready = adv1 (combinational; no dependency on in_valid).
- Latency and throughput: 2 cycles from accept to out_valid; one operation per cycle when there is no backpressure.
- Stage 1 registers the following when adv1:
  - isNaN: exponent all ones and mantissa != 0, per operand.
  - isSNaN: isNaN & mantissa[51] == 0, per operand.
  - bothZero: bits[62:0] of both operands == 0.
  - signA and signB.
  - magLt = A[62:0] < B[62:0] and magEq = A[62:0] == B[62:0] (unsigned 63-bit compares).
  - op and tag.
- Stage 2 computes the following when adv2:
  - eq = bothZero | (signA == signB & magEq).
  - lt when signs differ: signA & !bothZero.
  - lt when both signs are 0: magLt.
  - lt when both signs are 1: !magLt & !magEq.
  - Either NaN: eq = 0 and lt = 0.
  - FLE result = lt | eq; FLT result = lt; FEQ result = eq.
  - nv for FEQ: set only if either operand is sNaN.
  - nv for FLT/FLE: set if either operand is any NaN.
  - Op 11: result 0, nv 0, illegal 1.
- Signed zeros: +0 and -0 compare equal. FLT(-0, +0) = 0 and FLE(-0, +0) = 1.
- Flush:
  - in_flush clears s1_valid and s2_valid next edge, which has priority over advance.
  - An operation presented in the flush cycle is dropped; out_ready may still read 1 in that cycle.
- Reset mid-operation: asynchronously clears everything listed under Reset; in-flight operations are lost and no result is produced.
- Simultaneous events: accepting a new operation while the output drains in the same cycle is legal, with no bubble inserted.
- Data registers load only on their stage's advance. Flags are valid only while out_valid.

Decomposition:
- Shared package fp_pkg:
  - FP64 field positions: SIGN = 63, EXP = 62:52, MAN = 51:0.
  - EXP_ALL_ONES = 11'h7FF.
  - Compare opcode constants FP_CMP_FLE, FP_CMP_FLT, FP_CMP_FEQ.
- One sub-module, fp_classify: combinational per-operand isNaN, isSNaN and isZero. It is instantiated twice in stage 1 and reusable by the future FCLASS block.

Test Plan:
- FLT(1.0 = 0x3FF0000000000000, 2.0 = 0x4000000000000000) with in_ready = 1 -> out_valid 2 cycles later, out_data = 1, nv = 0. FLT(2.0, 1.0) -> out_data = 0.
- FEQ(0x8000000000000000, 0x0000000000000000) -> out_data = 1. FLT of the same pair -> 0. FLE of the same pair -> 1. nv = 0 in all three cases.
- FEQ(qNaN 0x7FF8000000000000, 1.0) -> out_data = 0, nv = 0. FLE of the same pair -> out_data = 0, nv = 1. FEQ(sNaN 0x7FF0000000000001, 1.0) -> nv = 1.
- Negatives: FLT(-2.0 = 0xC000000000000000, -1.0 = 0xBFF0000000000000) -> out_data = 1. FLE(-1.0, -2.0) -> out_data = 0.
- Backpressure: stream 4 operations back-to-back with in_ready held 0 for 3 cycles.
  - out_ready must drop once both stages are full.
  - Outputs must hold stable while stalled.
  - All 4 results must emerge in order with correct tags, with none lost or duplicated.
- Reset and flush:
  - Assert in_flush with 2 operations in flight -> no out_valid follows.
  - Pulse in_rst mid-stream -> all outputs go to 0 immediately and out_ready = 1 after release.
  - Op 11 -> out_data = 0, illegal = 1.
